// File: rtl/hand_bank.sv
// hand_bank: multi-hand baccarat card store and scorer.
//   Takes one card per cycle over a valid/ready handshake and files it into
//   one of NUM_HANDS hands (MAX_CARDS slots each), keeping a running mod-10
//   score per hand. A multi-cycle clear sweeps every hand, one per cycle.
// Ports:
//   slow_clock, reset        - clock, synchronous active-high reset
//   deal_valid/hand/card     - offered card, target hand, rank (1..13)
//   deal_ready               - card can be taken this cycle
//   clear                    - empty all hands (takes NUM_HANDS cycles)
//   hand_cards/count/score   - per-hand slots, card count, score 0..9
//   hand_full, natural       - count==MAX_CARDS; two-card 8/9
//   deal_error               - one-cycle pulse after a rejected card
//   total_dealt              - saturating accepted-card counter (survives clear)

// One hand: slot storage, count and running score.
module hand_bank_hand #(
    parameter int MAX_CARDS = 3,
    parameter int CW        = 2
) (
    input  logic                      slow_clock,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      wr,
    input  logic [3:0]                card,
    output logic [MAX_CARDS-1:0][3:0] slots,
    output logic [CW-1:0]             count,
    output logic [3:0]                score
);
    logic [3:0] v;
    logic [4:0] sum;
    logic [3:0] score_nxt;

    // 10/J/Q/K are worth nothing; max sum 9+9 needs one wrap only.
    always_comb begin
        v         = (card <= 4'd9) ? card : 4'd0;
        sum       = {1'b0, score} + {1'b0, v};
        score_nxt = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
    end

    always_ff @(posedge slow_clock) begin
        if (reset || clr) begin
            slots <= '0;
            count <= '0;
            score <= '0;
        end else if (wr) begin
            for (int s = 0; s < MAX_CARDS; s++)
                if (int'(count) == s) slots[s] <= card;
            count <= count + CW'(1);
            score <= score_nxt;
        end
    end
endmodule

module hand_bank #(
    parameter int NUM_HANDS = 2,
    parameter int MAX_CARDS = 3,
    parameter int HW        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    parameter int CW        = $clog2(MAX_CARDS + 1)
) (
    input  logic                            slow_clock,
    input  logic                            reset,
    input  logic                            deal_valid,
    input  logic [HW-1:0]                   deal_hand,
    input  logic [3:0]                      deal_card,
    output logic                            deal_ready,
    input  logic                            clear,
    output logic [NUM_HANDS*MAX_CARDS*4-1:0] hand_cards,
    output logic [NUM_HANDS*CW-1:0]         hand_count,
    output logic [NUM_HANDS*4-1:0]          hand_score,
    output logic [NUM_HANDS-1:0]            hand_full,
    output logic [NUM_HANDS-1:0]            natural,
    output logic                            deal_error,
    output logic [7:0]                      total_dealt
);
    typedef enum logic [0:0] {IDLE, CLEARING} state_t;

    state_t  state;
    logic [HW-1:0] ci;

    logic [NUM_HANDS-1:0][MAX_CARDS-1:0][3:0] cards_a;
    logic [NUM_HANDS-1:0][CW-1:0]             count_a;
    logic [NUM_HANDS-1:0][3:0]                score_a;

    logic xfer, hand_ok, card_ok, full_tgt, accept;

    assign deal_ready = (state == IDLE) && !clear;
    assign xfer       = deal_valid && deal_ready;
    assign hand_ok    = int'(deal_hand) < NUM_HANDS;
    assign card_ok    = (deal_card != 4'd0) && (deal_card <= 4'd13);

    // Fullness of the addressed hand; out-of-range index reads not-full
    // (it is rejected by hand_ok anyway).
    always_comb begin
        full_tgt = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++)
            if (int'(deal_hand) == h) full_tgt = hand_full[h];
    end

    assign accept = xfer && hand_ok && card_ok && !full_tgt;

    for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
        hand_bank_hand #(.MAX_CARDS(MAX_CARDS), .CW(CW)) u_hand (
            .slow_clock (slow_clock),
            .reset      (reset),
            .clr        ((state == CLEARING) && (ci == HW'(h))),
            .wr         (accept && (deal_hand == HW'(h))),
            .card       (deal_card),
            .slots      (cards_a[h]),
            .count      (count_a[h]),
            .score      (score_a[h])
        );
        assign hand_full[h] = int'(count_a[h]) == MAX_CARDS;
        assign natural[h]   = (int'(count_a[h]) == 2) && (score_a[h] >= 4'd8);
    end

    // Packed arrays flatten to hand-major, slot-minor order.
    assign hand_cards = cards_a;
    assign hand_count = count_a;
    assign hand_score = score_a;

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state       <= IDLE;
            ci          <= '0;
            deal_error  <= 1'b0;
            total_dealt <= '0;
        end else begin
            deal_error <= xfer && !accept;
            if (accept && total_dealt != 8'hFF)
                total_dealt <= total_dealt + 8'd1;
            case (state)
                IDLE: if (clear) begin
                    state <= CLEARING;
                    ci    <= '0;
                end
                CLEARING: begin
                    if (int'(ci) == NUM_HANDS - 1) begin
                        state <= IDLE;
                        ci    <= '0;
                    end else begin
                        ci <= ci + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hand_bank.sv
// Directed bench for hand_bank with NUM_HANDS=3, MAX_CARDS=3:
// a vector table of single-cycle deals with hand-computed expectations,
// then hand-written clear, reset-during-clear and saturation sequences.
module tb_hand_bank;
    localparam int NH = 3;
    localparam int MC = 3;
    localparam int HW = 2;
    localparam int CW = 2;

    logic                 slow_clock = 1'b0;
    logic                 reset      = 1'b1;
    logic                 deal_valid = 1'b0;
    logic [HW-1:0]        deal_hand  = '0;
    logic [3:0]           deal_card  = '0;
    logic                 clear      = 1'b0;
    logic                 deal_ready;
    logic [NH*MC*4-1:0]   hand_cards;
    logic [NH*CW-1:0]     hand_count;
    logic [NH*4-1:0]      hand_score;
    logic [NH-1:0]        hand_full;
    logic [NH-1:0]        natural;
    logic                 deal_error;
    logic [7:0]           total_dealt;

    hand_bank #(.NUM_HANDS(NH), .MAX_CARDS(MC)) dut (
        .slow_clock (slow_clock),
        .reset      (reset),
        .deal_valid (deal_valid),
        .deal_hand  (deal_hand),
        .deal_card  (deal_card),
        .deal_ready (deal_ready),
        .clear      (clear),
        .hand_cards (hand_cards),
        .hand_count (hand_count),
        .hand_score (hand_score),
        .hand_full  (hand_full),
        .natural    (natural),
        .deal_error (deal_error),
        .total_dealt(total_dealt)
    );

    always #5 slow_clock = ~slow_clock;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  hnd;
        logic [3:0]  crd;
        logic [35:0] cards;
        logic [5:0]  cnt;
        logic [11:0] scr;
        logic [2:0]  full;
        logic [2:0]  nat;
        logic        err;
        logic [7:0]  tot;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge slow_clock);
        #1;
    endtask

    task automatic deal(input int h, input int c);
        deal_valid = 1'b1;
        deal_hand  = HW'(h);
        deal_card  = 4'(c);
        cyc();
        deal_valid = 1'b0;
    endtask

    int exp_tot;

    initial begin
        // rst vld hnd crd  cards            cnt    scr      full   nat    err tot
        vq.push_back(vec_t'{1,0,0,0,  36'h000000000, 6'h00, 12'h000, 3'b000, 3'b000, 0, 8'd0});
        vq.push_back(vec_t'{0,1,0,9,  36'h000000009, 6'h01, 12'h009, 3'b000, 3'b000, 0, 8'd1});
        vq.push_back(vec_t'{0,1,1,8,  36'h000008009, 6'h05, 12'h089, 3'b000, 3'b000, 0, 8'd2});
        vq.push_back(vec_t'{1,0,0,0,  36'h000000000, 6'h00, 12'h000, 3'b000, 3'b000, 0, 8'd0});
        vq.push_back(vec_t'{0,1,0,7,  36'h000000007, 6'h01, 12'h007, 3'b000, 3'b000, 0, 8'd1});
        vq.push_back(vec_t'{0,1,0,13, 36'h0000000D7, 6'h02, 12'h007, 3'b000, 3'b000, 0, 8'd2});
        vq.push_back(vec_t'{0,1,0,2,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 0, 8'd3});
        vq.push_back(vec_t'{0,1,0,5,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 1, 8'd3});
        vq.push_back(vec_t'{0,0,0,0,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 0, 8'd3});
        vq.push_back(vec_t'{0,1,1,0,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 1, 8'd3});
        vq.push_back(vec_t'{0,0,0,0,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 0, 8'd3});
        vq.push_back(vec_t'{0,1,1,14, 36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 1, 8'd3});
        vq.push_back(vec_t'{0,0,0,0,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 0, 8'd3});
        vq.push_back(vec_t'{0,1,3,5,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 1, 8'd3});
        vq.push_back(vec_t'{0,0,0,0,  36'h0000002D7, 6'h03, 12'h009, 3'b001, 3'b000, 0, 8'd3});
        vq.push_back(vec_t'{0,1,1,8,  36'h0000082D7, 6'h07, 12'h089, 3'b001, 3'b000, 0, 8'd4});
        vq.push_back(vec_t'{0,1,1,1,  36'h0000182D7, 6'h0B, 12'h099, 3'b001, 3'b010, 0, 8'd5});
        vq.push_back(vec_t'{0,1,1,10, 36'h000A182D7, 6'h0F, 12'h099, 3'b011, 3'b000, 0, 8'd6});
        vq.push_back(vec_t'{0,1,2,4,  36'h004A182D7, 6'h1F, 12'h499, 3'b011, 3'b000, 0, 8'd7});

        for (int i = 0; i < vq.size(); i++) begin
            reset      = vq[i].rst;
            deal_valid = vq[i].vld;
            deal_hand  = vq[i].hnd;
            deal_card  = vq[i].crd;
            cyc();
            reset      = 1'b0;
            deal_valid = 1'b0;
            chk($sformatf("v%0d cards", i), 64'(hand_cards),  64'(vq[i].cards));
            chk($sformatf("v%0d count", i), 64'(hand_count),  64'(vq[i].cnt));
            chk($sformatf("v%0d score", i), 64'(hand_score),  64'(vq[i].scr));
            chk($sformatf("v%0d full",  i), 64'(hand_full),   64'(vq[i].full));
            chk($sformatf("v%0d nat",   i), 64'(natural),     64'(vq[i].nat));
            chk($sformatf("v%0d err",   i), 64'(deal_error),  64'(vq[i].err));
            chk($sformatf("v%0d total", i), 64'(total_dealt), 64'(vq[i].tot));
        end

        // clear together with a valid deal: deal dropped, hands swept in order
        clear = 1'b1; deal_valid = 1'b1; deal_hand = 2'd2; deal_card = 4'd4;
        #1;
        chk("clr ready0", 64'(deal_ready), 64'd0);
        cyc();
        clear = 1'b0; deal_valid = 1'b0;
        chk("clr c0 ready", 64'(deal_ready), 64'd0);
        chk("clr c0 count", 64'(hand_count), 64'h1F);
        chk("clr c0 total", 64'(total_dealt), 64'd7);
        chk("clr c0 err",   64'(deal_error), 64'd0);
        cyc();
        chk("clr c1 ready", 64'(deal_ready), 64'd0);
        chk("clr c1 count", 64'(hand_count), 64'h1C);
        chk("clr c1 cards", 64'(hand_cards), 64'h004A18000);
        cyc();
        chk("clr c2 ready", 64'(deal_ready), 64'd0);
        chk("clr c2 count", 64'(hand_count), 64'h10);
        chk("clr c2 cards", 64'(hand_cards), 64'h004000000);
        cyc();
        chk("clr c3 ready", 64'(deal_ready), 64'd1);
        chk("clr c3 count", 64'(hand_count), 64'h00);
        chk("clr c3 cards", 64'(hand_cards), 64'h0);
        chk("clr c3 score", 64'(hand_score), 64'h0);
        chk("clr c3 full",  64'(hand_full),  64'h0);
        chk("clr c3 total", 64'(total_dealt), 64'd7);

        // reset in the second CLEARING cycle
        deal(2, 9);
        chk("rmc pre count", 64'(hand_count), 64'h10);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rmc cards", 64'(hand_cards), 64'h0);
        chk("rmc count", 64'(hand_count), 64'h0);
        chk("rmc score", 64'(hand_score), 64'h0);
        chk("rmc total", 64'(total_dealt), 64'd0);
        chk("rmc err",   64'(deal_error), 64'd0);
        chk("rmc ready", 64'(deal_ready), 64'd1);
        deal(0, 3);
        chk("rmc deal count", 64'(hand_count), 64'h01);
        chk("rmc deal score", 64'(hand_score), 64'h003);

        // 256 accepted cards across clears: counter saturates
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        exp_tot = 0;
        for (int i = 0; i < 256; i++) begin
            deal((i % 9) / 3, (i % 13) + 1);
            exp_tot = (exp_tot == 255) ? 255 : exp_tot + 1;
            if (deal_error) chk($sformatf("sat err %0d", i), 64'(deal_error), 64'd0);
            if (i == 100 || i >= 253)
                chk($sformatf("sat total %0d", i), 64'(total_dealt), 64'(exp_tot));
            if (i % 9 == 8) begin
                clear = 1'b1;
                cyc();
                clear = 1'b0;
                repeat (NH) cyc();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
